// File: rtl/fixed_pe_loader.sv
// fixed_pe_loader: buffers one config frame from a word stream and
// replays it on the fixed_pe load bus, then issues the placement strobe.
module fixed_pe_loader #(
  parameter int N          = 16,
  parameter int BUS_WIDTH  = 32,
  parameter int DATA_WIDTH = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [BUS_WIDTH-1:0] s_data,
  input  logic                 place_go,
  output logic                 load_enable_out,
  output logic [BUS_WIDTH-1:0] load_out,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int CMX = (N > GAP_CYCLES) ? N : GAP_CYCLES;
  localparam int CMAX = (CMX > 7) ? CMX : 7;
  localparam int CW = $clog2(CMAX + 1);
  localparam int WW = $clog2(2 * N + 2);
  localparam int IW = $clog2(2 * N);

  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [CW-1:0] C_DUM = CW'(6);
  localparam logic [CW-1:0] C_SUM = CW'(N - 1);
  localparam logic [CW-1:0] C_GAP = CW'(GAP_CYCLES - 1);
  localparam logic [WW-1:0] W_ONE = WW'(1);
  localparam logic [WW-1:0] W_TWO = WW'(2);
  localparam logic [WW-1:0] W_LAST = WW'(2 * N + 1);
  localparam logic [IW-1:0] I_Y = IW'(N);

  typedef enum logic [3:0] {
    FILL,
    X_HDR,
    X_DUMMY,
    X_SUMS,
    GAP_XY,
    Y_HDR,
    Y_DUMMY,
    Y_SUMS,
    GAP_YP,
    WAIT_GO,
    PLACE,
    DONE
  } state_t;

  state_t state, nxt;

  logic [CW-1:0] cnt, cnt_d;
  logic [WW-1:0] widx;
  logic          go_q, go_d;
  logic          acc;
  logic          busy_d;
  logic [IW-1:0] ridx;
  logic [IW-1:0] widx_s;
  logic [BUS_WIDTH-1:0] load_d;

  logic [BUS_WIDTH-1:0]  cfg_c;
  logic [BUS_WIDTH-1:0]  cfg_s;
  logic [DATA_WIDTH-1:0] sums [2*N];

  assign acc = s_valid & s_ready;
  assign widx_s = IW'(widx - W_TWO);

  always_comb begin
    nxt = state;
    cnt_d = cnt;
    case (state)
      FILL: begin
        if (acc && (widx == W_LAST)) nxt = X_HDR;
      end
      X_HDR: begin
        nxt = X_DUMMY;
        cnt_d = '0;
      end
      X_DUMMY: begin
        if (cnt == C_DUM) begin
          nxt = X_SUMS;
          cnt_d = '0;
        end else begin
          cnt_d = cnt + C_ONE;
        end
      end
      X_SUMS: begin
        if (cnt == C_SUM) begin
          nxt = GAP_XY;
          cnt_d = '0;
        end else begin
          cnt_d = cnt + C_ONE;
        end
      end
      GAP_XY: begin
        if (cnt == C_GAP) begin
          nxt = Y_HDR;
          cnt_d = '0;
        end else begin
          cnt_d = cnt + C_ONE;
        end
      end
      Y_HDR: begin
        nxt = Y_DUMMY;
        cnt_d = '0;
      end
      Y_DUMMY: begin
        if (cnt == C_DUM) begin
          nxt = Y_SUMS;
          cnt_d = '0;
        end else begin
          cnt_d = cnt + C_ONE;
        end
      end
      Y_SUMS: begin
        if (cnt == C_SUM) begin
          nxt = GAP_YP;
          cnt_d = '0;
        end else begin
          cnt_d = cnt + C_ONE;
        end
      end
      GAP_YP: begin
        if (cnt == C_GAP) begin
          nxt = go_q ? PLACE : WAIT_GO;
          cnt_d = '0;
        end else begin
          cnt_d = cnt + C_ONE;
        end
      end
      WAIT_GO: begin
        if (go_q) nxt = PLACE;
      end
      PLACE: nxt = FILL;
      default: nxt = FILL;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    ridx = ((nxt == Y_SUMS) ? I_Y : '0) + IW'(cnt_d);
    load_d = '0;
    unique case (1'b1)
      (nxt == X_HDR):
        load_d = cfg_c;
      (nxt == X_DUMMY) && (cnt_d == '0):
        load_d = cfg_s;
      (nxt == X_SUMS) || (nxt == Y_SUMS):
        load_d = BUS_WIDTH'(sums[ridx]);
      default:
        load_d = '0;
    endcase
  end

  // Latch survives PLACE so a go in that cycle is kept for the next frame.
  assign go_d = place_go | (go_q & (state != PLACE));
  assign busy_d = (nxt != FILL) |
                  ((state == FILL) & (busy | acc));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
      cnt <= '0;
      widx <= '0;
      go_q <= 1'b0;
      s_ready <= 1'b0;
      load_enable_out <= 1'b0;
      load_out <= '0;
      busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= cnt_d;
      go_q <= go_d;
      if (acc) begin
        widx <= (widx == W_LAST) ? '0 : widx + W_ONE;
      end
      s_ready <= (nxt == FILL);
      load_enable_out <= (nxt == X_HDR) |
                         (nxt == Y_HDR) |
                         (nxt == PLACE);
      load_out <= load_d;
      busy <= busy_d;
      frame_done <= (state == PLACE);
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      if (widx == '0) begin
        cfg_c <= s_data;
      end else if (widx == W_ONE) begin
        cfg_s <= s_data;
      end else begin
        sums[widx_s] <= s_data[DATA_WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_fixed_pe_loader.sv
// Bench for fixed_pe_loader: per-cycle timeline model of the load bus
// plus pinned literal expectations.
module tb_fixed_pe_loader;

  localparam int N = 4;
  localparam int G = 2;
  localparam int BW = 32;
  localparam int DW = 16;
  localparam int MAXC = 600;

  logic clk = 1'b0;
  logic rst_n;
  logic s_valid;
  logic s_ready;
  logic [BW-1:0] s_data;
  logic place_go;
  logic load_enable_out;
  logic [BW-1:0] load_out;
  logic busy;
  logic frame_done;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  logic e_en [MAXC];
  logic e_rdy [MAXC];
  logic e_busy [MAXC];
  logic e_done [MAXC];
  logic [31:0] e_lo [MAXC];
  logic [31:0] fw [10];

  int r, ka, kb, kc, kd, ke;

  fixed_pe_loader #(
    .N(N),
    .BUS_WIDTH(BW),
    .DATA_WIDTH(DW),
    .GAP_CYCLES(G)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .place_go(place_go),
    .load_enable_out(load_enable_out),
    .load_out(load_out),
    .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on && rst_n && cyc < MAXC) begin
      chk("en", {31'b0, load_enable_out}, {31'b0, e_en[cyc]});
      chk("load", load_out, e_lo[cyc]);
      chk("ready", {31'b0, s_ready}, {31'b0, e_rdy[cyc]});
      chk("busy", {31'b0, busy}, {31'b0, e_busy[cyc]});
      chk("done", {31'b0, frame_done}, {31'b0, e_done[cyc]});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic at(input int t);
    while (cyc < t) tick();
  endtask

  // Expected bus timeline for a frame: first word at f, last at k, go at g.
  task automatic plan(input int f, input int k, input int g);
    int xs, yh, ys, pe, p;
    xs = k + 9;
    yh = xs + N + G;
    ys = yh + 8;
    pe = ys + N + G;
    if (g < 0) p = MAXC;
    else p = (pe > g + 2) ? pe : g + 2;
    for (int t = f + 1; t <= p && t < MAXC; t++) e_busy[t] = 1'b1;
    for (int t = k + 1; t <= p && t < MAXC; t++) e_rdy[t] = 1'b0;
    e_en[k+1] = 1'b1;
    e_lo[k+1] = fw[0];
    e_lo[k+2] = fw[1];
    e_en[yh] = 1'b1;
    for (int i = 0; i < N; i++) begin
      e_lo[xs+i] = {16'h0, fw[2+i][15:0]};
      e_lo[ys+i] = {16'h0, fw[2+N+i][15:0]};
    end
    if (p < MAXC) begin
      e_en[p] = 1'b1;
      e_done[p+1] = 1'b1;
    end
  endtask

  task automatic frame(input bit tog, input int gw, input int gk,
                       output int k);
    int f, st, g;
    f = cyc;
    st = tog ? 2 : 1;
    k = f + 9 * st;
    if (gw >= 0) g = f + gw * st;
    else if (gk >= 0) g = k + gk;
    else g = -1;
    plan(f, k, g);
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1;
      s_data = fw[i];
      place_go = (gw >= 0) && (i == gw || i == gw + 1);
      tick();
      s_valid = 1'b0;
      place_go = 1'b0;
      s_data = '0;
      if (tog && i < 9) tick();
    end
  endtask

  initial begin
    for (int t = 0; t < MAXC; t++) begin
      e_en[t] = 1'b0;
      e_lo[t] = '0;
      e_done[t] = 1'b0;
      e_busy[t] = 1'b0;
      e_rdy[t] = 1'b1;
    end
    rst_n = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    place_go = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b1;
    r = cyc;
    for (int t = 0; t <= r; t++) e_rdy[t] = 1'b0;
    chk_on = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'b0, s_ready}, 32'd0);
    chk("rst_load", load_out, 32'd0);
    at(r + 1);
    @(negedge clk);
    chk("rel_ready", {31'b0, s_ready}, 32'd1);
    at(r + 2);

    fw = '{32'd10, 32'd3, 32'd1, 32'd2, 32'd3, 32'd4,
           32'd5, 32'd6, 32'd7, 32'd8};
    frame(1'b0, -1, 40, ka);
    at(ka + 1);
    @(negedge clk);
    chk("A_hdr_en", {31'b0, load_enable_out}, 32'd1);
    chk("A_hdr", load_out, 32'd10);
    at(ka + 2);
    @(negedge clk);
    chk("A_swaps", load_out, 32'd3);
    at(ka + 9);
    @(negedge clk);
    chk("A_x0", load_out, 32'd1);
    at(ka + 15);
    @(negedge clk);
    chk("A_yhdr_en", {31'b0, load_enable_out}, 32'd1);
    at(ka + 23);
    @(negedge clk);
    chk("A_y0", load_out, 32'd5);
    at(ka + 40);
    place_go = 1'b1;
    tick();
    place_go = 1'b0;
    at(ka + 42);
    @(negedge clk);
    chk("A_place", {31'b0, load_enable_out}, 32'd1);
    at(ka + 43);
    @(negedge clk);
    chk("A_done", {31'b0, frame_done}, 32'd1);
    chk("A_ready", {31'b0, s_ready}, 32'd1);
    at(ka + 45);

    fw = '{32'd11, 32'd12, 32'd21, 32'd22, 32'd23, 32'd24,
           32'd31, 32'd32, 32'd33, 32'd34};
    frame(1'b1, 0, -1, kb);
    at(kb + 29);
    @(negedge clk);
    chk("B_place", {31'b0, load_enable_out}, 32'd1);
    at(kb + 30);
    @(negedge clk);
    chk("B_done", {31'b0, frame_done}, 32'd1);
    at(kb + 33);

    fw = '{32'hABCD_1234, 32'd7, 32'hABCD_1234, 32'd2, 32'd3,
           32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    frame(1'b0, -1, 1, kc);
    at(kc + 1);
    place_go = 1'b1;
    @(negedge clk);
    chk("C_swapc", load_out, 32'hABCD_1234);
    tick();
    place_go = 1'b0;
    at(kc + 9);
    @(negedge clk);
    chk("C_x0_trunc", load_out, 32'h0000_1234);
    at(kc + 31);

    fw = '{32'd40, 32'd41, 32'd42, 32'd43, 32'd44, 32'd45,
           32'd46, 32'd47, 32'd48, 32'd49};
    frame(1'b0, -1, -1, kd);
    at(kd + 11);
    rst_n = 1'b0;
    for (int t = kd + 11; t < MAXC; t++) begin
      e_en[t] = 1'b0;
      e_lo[t] = '0;
      e_done[t] = 1'b0;
      e_busy[t] = 1'b0;
      e_rdy[t] = (t > kd + 13);
    end
    #1;
    chk("D_abort_load", load_out, 32'd0);
    chk("D_abort_en", {31'b0, load_enable_out}, 32'd0);
    chk("D_abort_ready", {31'b0, s_ready}, 32'd0);
    at(kd + 13);
    rst_n = 1'b1;
    at(kd + 14);
    @(negedge clk);
    chk("D_rel_ready", {31'b0, s_ready}, 32'd1);
    at(kd + 15);

    fw = '{32'd50, 32'd51, 32'd60, 32'd61, 32'd62, 32'd63,
           32'd70, 32'd71, 32'd72, 32'd73};
    frame(1'b0, 0, -1, ke);
    at(ke + 1);
    @(negedge clk);
    chk("E_hdr", load_out, 32'd50);
    at(ke + 26);
    @(negedge clk);
    chk("E_y3", load_out, 32'd73);
    at(ke + 29);
    @(negedge clk);
    chk("E_place", {31'b0, load_enable_out}, 32'd1);
    at(ke + 32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
